// File: rtl/ftdi_rx_fifo_pkg.sv
// Shared definitions for ftdi_rx_fifo: default depth, handshake FSM encodings and a clog2 helper.
// The optional watermark feature is enabled by defining FTDI_RX_FIFO_STATS_EN.
package ftdi_rx_fifo_pkg;

  localparam int FTDI_RX_FIFO_DEPTH = 16;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rd_state_t;

  function automatic int ftdi_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ftdi_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module ftdi_fifo_mem #(
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 in_clk,
  input  logic                 in_wr_en,
  input  logic [ADDR_BITS-1:0] in_wr_addr,
  input  logic [DATA_BITS-1:0] in_wr_data,
  input  logic [ADDR_BITS-1:0] in_rd_addr,
  output logic [DATA_BITS-1:0] out_rd_data
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge in_clk) begin
    if (in_wr_en) begin
      r_mem[in_wr_addr] <= in_wr_data;
    end
  end

  assign out_rd_data = r_mem[in_rd_addr];

endmodule

// File: rtl/ftdi_rx_fifo.sv
// Elastic byte FIFO with 4-phase req/ack on both sides and an almost-full rx-enable hint.
// Define FTDI_RX_FIFO_STATS_EN to add the level high-watermark (in_stats_clr / out_max_level).
module ftdi_rx_fifo
  import ftdi_rx_fifo_pkg::*;
#(
  parameter int  FIFO_DEPTH        = FTDI_RX_FIFO_DEPTH,
  parameter int  FIFO_DATA_BITS    = 8,
  parameter int  FIFO_AFULL_MARGIN = 2,
  localparam int ADDR_BITS         = ftdi_clog2(FIFO_DEPTH)
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_wr_req,
  input  logic [FIFO_DATA_BITS-1:0] in_wr_data,
  output logic                      out_wr_ack,
  output logic                      out_rd_req,
  output logic [FIFO_DATA_BITS-1:0] out_rd_data,
  input  logic                      in_rd_ack,
  output logic                      out_rx_enable,
  output logic                      out_empty,
  output logic                      out_full
`ifdef FTDI_RX_FIFO_STATS_EN
  ,
  input  logic                      in_stats_clr,
  output logic [ADDR_BITS:0]        out_max_level
`endif
);

  localparam logic [ADDR_BITS:0] C_DEPTH  = (ADDR_BITS + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0] C_MARGIN = (ADDR_BITS + 1)'(FIFO_AFULL_MARGIN);

  wr_state_t                 r_wstate;
  wr_state_t                 w_wstate_next;
  rd_state_t                 r_rstate;
  rd_state_t                 w_rstate_next;
  logic [ADDR_BITS-1:0]      r_wptr;
  logic [ADDR_BITS-1:0]      r_rptr;
  logic [ADDR_BITS:0]        r_level;
  logic [ADDR_BITS:0]        w_level_next;
  logic [ADDR_BITS:0]        w_free_next;
  logic                      r_empty;
  logic                      r_full;
  logic                      r_rx_en;
  logic [FIFO_DATA_BITS-1:0] r_rd_data;
  logic [FIFO_DATA_BITS-1:0] w_mem_rd_data;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_load;

  ftdi_fifo_mem #(
    .DEPTH     (FIFO_DEPTH),
    .DATA_BITS (FIFO_DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .in_clk      (in_clk),
    .in_wr_en    (w_push),
    .in_wr_addr  (r_wptr),
    .in_wr_data  (in_wr_data),
    .in_rd_addr  (r_rptr),
    .out_rd_data (w_mem_rd_data)
  );

  // Full is taken from the registered level, so a pop never makes room in the same cycle.
  always_comb begin
    w_wstate_next = r_wstate;
    w_push        = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (in_wr_req && !r_full) begin
          w_push        = 1'b1;
          w_wstate_next = W_ACK;
        end
      end
      W_ACK: begin
        if (!in_wr_req) begin
          w_wstate_next = W_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_rstate_next = r_rstate;
    w_pop         = 1'b0;
    w_load        = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (!r_empty && !in_rd_ack) begin
          w_load        = 1'b1;
          w_rstate_next = R_REQ;
        end
      end
      R_REQ: begin
        if (in_rd_ack) begin
          w_pop         = 1'b1;
          w_rstate_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (!in_rd_ack) begin
          w_rstate_next = R_IDLE;
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + 1'b1;
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - 1'b1;
    end
    w_free_next = C_DEPTH - w_level_next;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_rx_en   <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_level <= w_level_next;
      r_empty <= (w_level_next == '0);
      r_full  <= (w_level_next == C_DEPTH);
      r_rx_en <= (w_free_next > C_MARGIN);
      // Head byte is captured once per request so it stays stable while req is high.
      if (w_load) begin
        r_rd_data <= w_mem_rd_data;
      end
    end
  end

`ifdef FTDI_RX_FIFO_STATS_EN
  logic [ADDR_BITS:0] r_max_level;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_max_level <= '0;
    end else if (in_stats_clr) begin
      r_max_level <= r_level;
    end else if (r_level > r_max_level) begin
      r_max_level <= r_level;
    end
  end

  assign out_max_level = r_max_level;
`endif

  assign out_wr_ack    = (r_wstate == W_ACK);
  assign out_rd_req    = (r_rstate == R_REQ);
  assign out_rd_data   = r_rd_data;
  assign out_rx_enable = r_rx_en;
  assign out_empty     = r_empty;
  assign out_full      = r_full;

endmodule

// File: tb/tb_ftdi_rx_fifo.sv
// Self-checking bench for ftdi_rx_fifo: vector table, handshake corner cases and queue-model streaming.
// Watermark checks are compiled in when FTDI_RX_FIFO_STATS_EN is defined.
module tb_ftdi_rx_fifo;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       wr_req  = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_ack  = 1'b0;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rx_en;
  logic       empty;
  logic       full;
`ifdef FTDI_RX_FIFO_STATS_EN
  logic       stats_clr = 1'b0;
  logic [4:0] max_level;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] model_q[$];
  logic [7:0] got;
  logic [7:0] got_a;

  typedef struct {
    logic [7:0] data;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_rx_en;
    logic       exp_rd_req;
    logic [7:0] exp_rd_data;
  } vec_t;
  vec_t tbl[16];

  ftdi_rx_fifo dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_wr_req     (wr_req),
    .in_wr_data    (wr_data),
    .out_wr_ack    (wr_ack),
    .out_rd_req    (rd_req),
    .out_rd_data   (rd_data),
    .in_rd_ack     (rd_ack),
    .out_rx_enable (rx_en),
    .out_empty     (empty),
    .out_full      (full)
`ifdef FTDI_RX_FIFO_STATS_EN
    ,
    .in_stats_clr  (stats_clr),
    .out_max_level (max_level)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    int n;
    wr_data = d;
    wr_req  = 1'b1;
    n = 0;
    while (!wr_ack && n < 64) begin
      tick();
      n++;
    end
    check("wr_ack_rise", 32'(wr_ack), 1);
    if (wr_ack) begin
      model_q.push_back(d);
    end
    wr_req = 1'b0;
    n = 0;
    while (wr_ack && n < 64) begin
      tick();
      n++;
    end
    check("wr_ack_fall", 32'(wr_ack), 0);
    $display("push data=%02h level=%0d", d, model_q.size());
  endtask

  task automatic pop_byte(output logic [7:0] d);
    int n;
    n = 0;
    while (!rd_req && n < 64) begin
      tick();
      n++;
    end
    check("rd_req_rise", 32'(rd_req), 1);
    d = rd_data;
    rd_ack = 1'b1;
    n = 0;
    while (rd_req && n < 64) begin
      tick();
      n++;
    end
    check("rd_req_fall", 32'(rd_req), 0);
    rd_ack = 1'b0;
    tick();
    if (model_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL model_underflow: got %02h expected no byte", d);
    end else begin
      check("rd_data_order", 32'(d), 32'(model_q.pop_front()));
    end
    $display("pop  data=%02h level=%0d", d, model_q.size());
  endtask

  task automatic check_flags(input string nm);
    check({nm, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({nm, "_full"},  32'(full),  32'(model_q.size() == 16));
    check({nm, "_rx_en"}, 32'(rx_en), 32'((16 - model_q.size()) > 2));
  endtask

  initial begin
    // Vector table: 16 pushes with the reader stalled on the first byte.
    for (int i = 0; i < 16; i++) begin
      tbl[i].data        = 8'(i);
      tbl[i].exp_empty   = 1'b0;
      tbl[i].exp_full    = (i == 15);
      tbl[i].exp_rx_en   = (i < 13);
      tbl[i].exp_rd_req  = 1'b1;
      tbl[i].exp_rd_data = 8'h00;
    end

    repeat (3) tick();
    check("rst_empty",   32'(empty),   1);
    check("rst_full",    32'(full),    0);
    check("rst_rx_en",   32'(rx_en),   1);
    check("rst_wr_ack",  32'(wr_ack),  0);
    check("rst_rd_req",  32'(rd_req),  0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    tick();

    // Single byte latency.
    wr_data = 8'hA5;
    wr_req  = 1'b1;
    tick();
    check("t1_ack_rise", 32'(wr_ack), 1);
    check("t1_req_early", 32'(rd_req), 0);
    model_q.push_back(8'hA5);
    wr_req = 1'b0;
    tick();
    check("t1_ack_fall", 32'(wr_ack), 0);
    check("t1_rd_req", 32'(rd_req), 1);
    check("t1_rd_data", 32'(rd_data), 32'h0A5);
    rd_ack = 1'b1;
    tick();
    check("t1_req_drop", 32'(rd_req), 0);
    check("t1_empty", 32'(empty), 1);
    void'(model_q.pop_front());
    rd_ack = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      push_byte(tbl[i].data);
      check("tbl_empty",   32'(empty),   32'(tbl[i].exp_empty));
      check("tbl_full",    32'(full),    32'(tbl[i].exp_full));
      check("tbl_rx_en",   32'(rx_en),   32'(tbl[i].exp_rx_en));
      check("tbl_rd_req",  32'(rd_req),  32'(tbl[i].exp_rd_req));
      check("tbl_rd_data", 32'(rd_data), 32'(tbl[i].exp_rd_data));
    end

    // 17th byte is held off until a pop frees one entry.
    wr_data = 8'h10;
    wr_req  = 1'b1;
    repeat (5) tick();
    check("full_no_ack", 32'(wr_ack), 0);
    check("full_flag", 32'(full), 1);
    pop_byte(got);
    check("full_first_pop", 32'(got), 0);
    check("full_ack_after_pop", 32'(wr_ack), 1);
    if (wr_ack) begin
      model_q.push_back(8'h10);
    end
    wr_req = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      pop_byte(got);
      check("full_drain_seq", 32'(got), 32'(i + 1));
    end
    check_flags("drained");

    // Request held for 10 cycles writes exactly one byte.
    wr_data = 8'h3C;
    wr_req  = 1'b1;
    tick();
    if (wr_ack) begin
      model_q.push_back(8'h3C);
    end
    repeat (9) tick();
    check("hold_ack", 32'(wr_ack), 1);
    wr_req = 1'b0;
    tick();
    check("hold_ack_fall", 32'(wr_ack), 0);
    pop_byte(got);
    check("hold_data", 32'(got), 32'h3C);
    repeat (4) tick();
    check("hold_single_req", 32'(rd_req), 0);
    check("hold_single_empty", 32'(empty), 1);

    // Aligned streaming across pointer wrap.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_byte(8'(i));
          tick();
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          pop_byte(got_a);
          check("stream_seq", 32'(got_a), 32'(j));
        end
      end
    join
    check_flags("stream");

    // Randomized traffic against the queue model.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          push_byte(8'($urandom_range(0, 255)));
        end
      end
      begin
        repeat (20) tick();
        for (int j = 0; j < 60; j++) begin
          repeat ($urandom_range(0, 4)) tick();
          pop_byte(got);
        end
      end
    join
    check_flags("random");

    // Asynchronous reset in the middle of both handshakes.
    for (int i = 0; i < 5; i++) begin
      push_byte(8'(8'h50 + i));
    end
    tick();
    check("pre_rst_rd_req", 32'(rd_req), 1);
    wr_data = 8'h55;
    wr_req  = 1'b1;
    tick();
    check("pre_rst_wr_ack", 32'(wr_ack), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_wr_ack",  32'(wr_ack),  0);
    check("arst_rd_req",  32'(rd_req),  0);
    check("arst_empty",   32'(empty),   1);
    check("arst_rd_data", 32'(rd_data), 0);
    wr_req = 1'b0;
    model_q.delete();
    #3 rst = 1'b0;
    repeat (5) tick();
    check("post_rst_no_req", 32'(rd_req), 0);
    check("post_rst_empty", 32'(empty), 1);
    push_byte(8'h77);
    pop_byte(got);
    check("post_rst_data", 32'(got), 32'h77);

`ifdef FTDI_RX_FIFO_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    tick();
    check("wm_reset", 32'(max_level), 0);
    for (int i = 0; i < 9; i++) begin
      push_byte(8'(8'h90 + i));
    end
    for (int i = 0; i < 9; i++) begin
      pop_byte(got);
    end
    tick();
    check("wm_peak", 32'(max_level), 9);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("wm_clear", 32'(max_level), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ftdi_rx_fifo.md
Name: ftdi_rx_fifo

Overview:
- Elastic byte buffer between the FTDI controller's receive side (out_rx_data / out_rx_hsk_req / in_rx_hsk_ack) and the I/O synchronizer feeding the 3-wire master.
- Decouples USB burst arrival from slow 3-wire transactions.
- Both sides use a 4-phase req/ack handshake; full FIFO applies backpressure by withholding ack.
- Drives an rx-enable hint so the controller stops reading the FTDI chip before the buffer fills.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; power of two, minimum 4.
- FIFO_DATA_BITS, 8, entry width.
- FIFO_AFULL_MARGIN, 2, out_rx_enable deasserts when free entries are at or below this value; must be less than FIFO_DEPTH.

Ports:
- in_clk  input  1  system clock (clk_top_main).
- in_rst  input  1  asynchronous active-high reset.
- in_wr_req  input  1  upstream 4-phase request; data valid while high.
- in_wr_data  input  FIFO_DATA_BITS  upstream byte.
- out_wr_ack  output  1  upstream acknowledge.
- out_rd_req  output  1  downstream 4-phase request.
- out_rd_data  output  FIFO_DATA_BITS  head byte; stable while out_rd_req is high.
- in_rd_ack  input  1  downstream acknowledge.
- out_rx_enable  output  1  high when free entries are greater than FIFO_AFULL_MARGIN.
- out_empty  output  1  level == 0.
- out_full  output  1  level == FIFO_DEPTH.

Behaviour:
- Storage and pointers:
  - Storage is a register array; ADDR_BITS = clog2(FIFO_DEPTH).
  - Read and write pointers are ADDR_BITS wide and wrap naturally at FIFO_DEPTH-1 to 0.
  - level is ADDR_BITS+1 wide and is the single source of full/empty.
- Reset (async, in_rst=1): pointers=0, level=0, out_wr_ack=0, out_rd_req=0, out_rd_data=0, out_empty=1, out_full=0, out_rx_enable=1. Storage contents are not reset.
- Write FSM, states W_IDLE and W_ACK:
  - W_IDLE, in_wr_req=1 and not full: write in_wr_data at wptr, wptr+1, level+1, out_wr_ack=1 next cycle, go to W_ACK.
  - W_IDLE, in_wr_req=1 and full: stay; ack is withheld until a pop frees space, then the write proceeds that cycle.
  - W_ACK: hold ack until in_wr_req=0, then clear ack next cycle and return to W_IDLE. One byte per handshake; no re-write while req stays high.
- Read FSM, states R_IDLE, R_REQ, R_WAIT:
  - R_IDLE, level>0 and in_rd_ack=0: load out_rd_data from mem[rptr], assert out_rd_req, go to R_REQ.
  - R_REQ, in_rd_ack=1: pop (rptr+1, level-1), drop out_rd_req next cycle, go to R_WAIT.
  - R_WAIT, in_rd_ack=0: go to R_IDLE.
  - out_rd_data is held constant from req rise until the next load.
- Simultaneous push and pop in one cycle: both take effect and level is unchanged. Push at full with concurrent pop is not allowed; full is evaluated on the registered level.
- Latency: a write at edge N into an empty FIFO with an idle reader gives out_rd_req high after edge N+1.
- Flags: out_empty, out_full and out_rx_enable are registered and update on the same edge as level.
- Reset mid-handshake: all handshake outputs drop immediately and the buffered bytes are discarded. Upstream and downstream must restart from req=0.

Optional Feature:
- Macro FTDI_RX_FIFO_STATS_EN.
- Defined:
  - Adds in_stats_clr (input, 1) and out_max_level (output, ADDR_BITS+1).
  - out_max_level is a high-watermark of level, updated each cycle level exceeds it.
  - Cleared to 0 by reset. Loaded with the current level by in_stats_clr=1; clear has priority over update that cycle.
- Undefined: neither port exists and there is no watermark logic.

Decomposition:
- Shared package/header project_config.v holds:
  - `FTDI_RX_FIFO_DEPTH default;
  - FSM state encodings (W_IDLE/W_ACK as 1 bit; R_IDLE/R_REQ/R_WAIT as 2 bits);
  - a clog2 constant function.
- One natural sub-module: ftdi_fifo_mem, a simple dual-port register array (write enable/address/data, asynchronous read address/data). The two handshake FSMs and the level counter stay in the top of this block.

Test Plan:
- Reset, then one write of 0xA5 (4-phase) -> out_wr_ack rises 1 cycle after req; out_rd_req rises 1 cycle after ack with out_rd_data=0xA5; after in_rd_ack, out_empty=1.
- 16 writes 0x00..0x0F with reader stalled (DEPTH=16) -> out_rx_enable drops after the 14th byte; out_full=1 after the 16th; a 17th req (0x10) gets no ack until one pop, then is acked and read out last, in order 0x01..0x10.
- Continuous streaming with write and read handshakes aligned so push and pop coincide -> level stays constant and the 40-byte sequence 0x00..0x27 is received in order across pointer wrap-around.
- Reset asserted while out_rd_req=1 and 5 bytes are buffered -> out_rd_req=0, out_wr_ack=0, out_empty=1 asynchronously; no stale byte is presented after reset release.
- Upstream holds in_wr_req high for 10 cycles -> exactly one byte is written and level increments by 1.
- With FTDI_RX_FIFO_STATS_EN: fill to 9, drain to 0 -> out_max_level=9; pulse in_stats_clr -> out_max_level=0.
